seq_serializer: RTL

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- definitions shared by the serializer and the downstream pattern
// detector.
//   SEQ_WIDTH      : default parallel word width
//   ser_state_e    : serializer FSM states (IDLE, SHIFT, PARITY)
//   even_parity32  : XOR-reduction helper used when SER_PARITY_EN is defined
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int SEQ_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;

    // Even parity of a zero-extended word: XOR of all bits.
    function automatic logic even_parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer -- parallel-to-serial converter, MSB first, with a one-word
// holding register so consecutive words stream without gaps.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit after
// each word's data bits (word_done then marks the parity bit).
//
// Ports
//   clk        : system clock, rising edge
//   rstn       : synchronous active-low reset
//   din        : parallel word (WIDTH bits)
//   din_valid  : din holds a valid word
//   din_ready  : block can accept din this cycle (!hold_full, 0 in reset)
//   sout       : serial stream bit (to the downstream pattern detector)
//   sout_valid : sout carries a stream bit this cycle
//   word_done  : pulse on the final bit of each word
//   busy       : shifter or holding register occupied
// -----------------------------------------------------------------------------
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept_s;
    logic load_hold_s;
    logic load_din_s;

    // Ready depends only on the holding register; forced low during reset.
    assign din_ready = rstn & ~hold_full_q;
    assign accept_s  = din_valid & din_ready;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_cnt_d    = bit_cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        word_done_d  = 1'b0;
        load_hold_s  = 1'b0;
        load_din_s   = 1'b0;
`ifdef SER_PARITY_EN
        par_d        = par_q;
`endif

        case (state_q)
            IDLE: begin
                // A held word has priority; otherwise an accepted word goes
                // straight into the shifter so its MSB appears next cycle.
                if (hold_full_q) begin
                    load_hold_s = 1'b1;
                end else if (accept_s) begin
                    load_din_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_CNT) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    if (hold_full_q) begin
                        load_hold_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + ONE_CNT;
                end
            end
            PARITY: begin
`ifdef SER_PARITY_EN
                if (hold_full_q) begin
                    load_hold_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_hold_s) begin
            state_d   = SHIFT;
            shift_d   = hold_q;
            bit_cnt_d = '0;
`ifdef SER_PARITY_EN
            par_d     = even_parity32(32'(hold_q));
`endif
        end else if (load_din_s) begin
            state_d   = SHIFT;
            shift_d   = din;
            bit_cnt_d = '0;
`ifdef SER_PARITY_EN
            par_d     = even_parity32(32'(din));
`endif
        end else begin
            shift_d = shift_d;
        end

        // Holding register: an accept that did not go straight to the
        // shifter lands here; a reload empties it unless refilled.
        if (accept_s && !load_din_s) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end else if (load_hold_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        // Outputs are registered, derived from the next state.
        case (state_d)
            SHIFT: begin
                sout_d       = shift_d[WIDTH-1];
                sout_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                word_done_d  = 1'b0;
`else
                word_done_d  = (bit_cnt_d == LAST_CNT);
`endif
            end
            PARITY: begin
`ifdef SER_PARITY_EN
                sout_d       = par_d;
                sout_valid_d = 1'b1;
                word_done_d  = 1'b1;
`else
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                word_done_d  = 1'b0;
`endif
            end
            default: begin
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                word_done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE) || hold_full_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            bit_cnt_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            bit_cnt_q    <= bit_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            word_done_q  <= word_done_d;
            busy_q       <= busy_d;
`ifdef SER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign word_done  = word_done_q;
    assign busy       = busy_q;

endmodule
